// File: rtl/sc_pkg.sv
// Shared constants, FSM state type and CRC helper for the slow-control
// load sequencer.
package sc_pkg;

  localparam int FRAME_LEN_DEF = 829;

  // CRC-16-CCITT, fed one bit at a time, most significant bit first.
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SC_RST = 3'd1,
    ST_LOAD1  = 3'd2,
    ST_SHIFT1 = 3'd3,
    ST_LOAD2  = 3'd4,
    ST_SHIFT2 = 3'd5,
    ST_CHECK  = 3'd6
  } sc_state_e;

  // One serial CRC step: the feedback bit is the outgoing MSB xor the new bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sc_crc16_serial.sv
// Bit-serial CRC-16 accumulator. init has priority over en so a new frame
// always starts from the seed value.
module sc_crc16_serial
  import sc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // Reseed on init, otherwise fold in one bit per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/sc_load_controller.sv
// Sequencer for the MAROC slow-control serial load: ASIC reset pulse,
// parallel load of the frame transmitter, bit counting and clock gating,
// with an optional second pass whose returned bits are CRC-checked against
// the bits sent in the first pass. CNT_W must satisfy 2**CNT_W > FRAME_LEN
// and 2**CNT_W >= RST_CYCLES.
//
// Handshake: start and abort are single-cycle pulses sampled on the rising
// clock edge; start is honoured only in IDLE and only when abort is low,
// abort is honoured in every non-IDLE state; there is no back-pressure.
module sc_load_controller
  import sc_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int RST_CYCLES = 8,
  parameter int VERIFY     = 1,
  parameter int CNT_W      = 10
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      abort,
  input  logic      d_sc_mon,
  input  logic      q_sc,
  output logic      load,
  output logic      shift_en,
  output logic      ck_en,
  output logic      rstn_sc,
  output logic      busy,
  output logic      done,
  output logic      crc_err,
  output logic      aborted,
  output sc_state_e state_dbg
);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);

  sc_state_e        state;
  logic [CNT_W-1:0] cnt;
  // shift_d tracks shift_en one cycle late because the transmitter's d_sc is
  // registered; shift_d_rx marks that the delayed bit belongs to pass 2.
  logic             shift_d;
  logic             shift_d_rx;
  logic             crc_init;
  logic [15:0]      crc_tx;
  logic [15:0]      crc_rx;

  assign crc_init  = (state == ST_IDLE) && start && !abort;
  assign ck_en     = shift_d;
  assign state_dbg = state;

  sc_crc16_serial u_crc_tx (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (shift_d && !shift_d_rx),
    .din  (d_sc_mon),
    .crc  (crc_tx)
  );

  sc_crc16_serial u_crc_rx (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (shift_d && shift_d_rx),
    .din  (q_sc),
    .crc  (crc_rx)
  );

  // Sequencer FSM with registered pin controls and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift_d    <= 1'b0;
      shift_d_rx <= 1'b0;
      load       <= 1'b0;
      shift_en   <= 1'b0;
      rstn_sc    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      crc_err    <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done       <= 1'b0;
      shift_d    <= shift_en;
      shift_d_rx <= (state == ST_SHIFT2);
      if ((state != ST_IDLE) && abort) begin
        // Abandon the load; pulse the ASIC reset so it does not sit on a
        // partially shifted frame with the clock stopped mid-word.
        state      <= ST_IDLE;
        cnt        <= '0;
        shift_d    <= 1'b0;
        shift_d_rx <= 1'b0;
        load       <= 1'b0;
        shift_en   <= 1'b0;
        rstn_sc    <= 1'b0;
        busy       <= 1'b0;
        aborted    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            rstn_sc <= 1'b1;
            if (start && !abort) begin
              state   <= ST_SC_RST;
              cnt     <= '0;
              rstn_sc <= 1'b0;
              busy    <= 1'b1;
              crc_err <= 1'b0;
              aborted <= 1'b0;
            end
          end
          ST_SC_RST: begin
            if (cnt == RST_LAST) begin
              state   <= ST_LOAD1;
              cnt     <= '0;
              rstn_sc <= 1'b1;
              load    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_LOAD1: begin
            state    <= ST_SHIFT1;
            cnt      <= '0;
            load     <= 1'b0;
            shift_en <= 1'b1;
          end
          ST_SHIFT1: begin
            if (cnt == FRAME_LAST) begin
              cnt      <= '0;
              shift_en <= 1'b0;
              if (VERIFY != 0) begin
                state <= ST_LOAD2;
                load  <= 1'b1;
              end else begin
                state <= ST_CHECK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_LOAD2: begin
            state    <= ST_SHIFT2;
            cnt      <= '0;
            load     <= 1'b0;
            shift_en <= 1'b1;
          end
          ST_SHIFT2: begin
            if (cnt == FRAME_LAST) begin
              state    <= ST_CHECK;
              cnt      <= '0;
              shift_en <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            // First cycle lets the last delayed bit reach the CRC; the
            // second cycle reports.
            if (cnt == '0) begin
              cnt <= cnt + 1'b1;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (VERIFY != 0) begin
                crc_err <= (crc_tx != crc_rx);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sc_load_controller.sv
// Bench for the slow-control load sequencer: one instance with readback
// verification, one single-pass instance, each wired to a behavioural
// frame transmitter and an ASIC shift-register model.
`timescale 1ns/1ps
module tb_sc_load_controller;

  localparam int FL = 829;
  localparam int RC = 8;
  localparam int EXP_DONE_V = RC + 2 * (FL + 1) + 2;
  localparam int EXP_DONE_S = RC + (FL + 1) + 2;
  localparam int FLIP_POS   = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #100 clk = ~clk;

  logic [1:0] start, abort, q_sc, d_sc;
  logic [1:0] load, shift_en, ck_en, rstn_sc, busy, done, crc_err, aborted;
  sc_pkg::sc_state_e st0, st1;

  sc_load_controller #(.FRAME_LEN(FL), .RST_CYCLES(RC), .VERIFY(1), .CNT_W(10)) dut_v (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .d_sc_mon(d_sc[0]), .q_sc(q_sc[0]), .load(load[0]), .shift_en(shift_en[0]),
    .ck_en(ck_en[0]), .rstn_sc(rstn_sc[0]), .busy(busy[0]), .done(done[0]),
    .crc_err(crc_err[0]), .aborted(aborted[0]), .state_dbg(st0)
  );

  sc_load_controller #(.FRAME_LEN(FL), .RST_CYCLES(RC), .VERIFY(0), .CNT_W(10)) dut_s (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .d_sc_mon(d_sc[1]), .q_sc(q_sc[1]), .load(load[1]), .shift_en(shift_en[1]),
    .ck_en(ck_en[1]), .rstn_sc(rstn_sc[1]), .busy(busy[1]), .done(done[1]),
    .crc_err(crc_err[1]), .aborted(aborted[1]), .state_dbg(st1)
  );

  // ---------------- environment models ----------------
  logic [FL-1:0] frame [2];
  logic [FL-1:0] tx_sr [2];
  logic [FL-1:0] asic_sr [2];
  int            ck_cnt [2];
  logic [1:0]    flip_en;

  // Transmitter: parallel load, then MSB-first shift into a registered d_sc.
  // ASIC: shifts d_sc in on every gated clock, returns its oldest bit on q_sc.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        d_sc[i]    <= 1'b0;
        tx_sr[i]   <= '0;
        asic_sr[i] <= '0;
        ck_cnt[i]  <= 0;
      end else begin
        if (load[i]) begin
          tx_sr[i] <= frame[i];
        end else if (shift_en[i]) begin
          d_sc[i]  <= tx_sr[i][FL-1];
          tx_sr[i] <= tx_sr[i] << 1;
        end
        if (!rstn_sc[i]) begin
          asic_sr[i] <= '0;
          ck_cnt[i]  <= 0;
        end else if (ck_en[i]) begin
          asic_sr[i] <= {asic_sr[i][FL-2:0], d_sc[i]};
          ck_cnt[i]  <= ck_cnt[i] + 1;
        end
      end
    end
  end

  // Optional corruption of one returned bit of pass 2.
  assign q_sc[0] = asic_sr[0][FL-1] ^ (flip_en[0] && (ck_cnt[0] == FL + FLIP_POS));
  assign q_sc[1] = asic_sr[1][FL-1] ^ (flip_en[1] && (ck_cnt[1] == FL + FLIP_POS));

  // ---------------- reference model ----------------
  // CRC-16-CCITT over the frame in transmit order, optionally with one bit
  // position inverted (flip_at < 0 means no corruption).
  function automatic logic [15:0] ref_crc(input logic [FL-1:0] f, input int flip_at);
    logic [15:0] c;
    logic        b;
    c = 16'hFFFF;
    for (int i = 0; i < FL; i++) begin
      b = f[FL-1-i] ^ (i == flip_at);
      if (c[15] ^ b) c = (c << 1) ^ 16'h1021;
      else           c = c << 1;
    end
    return c;
  endfunction

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic rand_frame(input int idx);
    for (int j = 0; j < FL; j++) frame[idx][j] = 1'($urandom_range(0, 1));
  endtask

  // Called at a falling edge; returns at the falling edge after start is taken.
  task automatic pulse_start(input int idx);
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
  endtask

  // Samples from the current falling edge for ncyc further cycles and
  // gathers activity statistics.
  task automatic watch(input int idx, input int ncyc, output int done_at, output int n_done,
                       output int rst_low, output int loads, output int cks);
    done_at = -1; n_done = 0; rst_low = 0; loads = 0; cks = 0;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) @(negedge clk);
      if (done[idx]) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (!rstn_sc[idx]) rst_low++;
      if (load[idx]) loads++;
      if (ck_en[idx]) cks++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] got;
    for (int i = 0; i < 2; i++) begin
      got = {load[i], shift_en[i], ck_en[i], rstn_sc[i], busy[i], done[i], crc_err[i], aborted[i]};
      checks++;
      if (got !== 8'b0001_0000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b expected %b", i, got, 8'b0001_0000);
      end
    end
    checks++;
    if (st0 !== sc_pkg::ST_IDLE || st1 !== sc_pkg::ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d expected IDLE", st0, st1);
    end
  endtask

  task automatic test_verify_ok();
    int done_at, n_done, rst_low, loads, cks;
    rand_frame(0);
    flip_en[0] = 1'b0;
    pulse_start(0);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL verify_busy: got %b expected 1", busy[0]); end
    watch(0, EXP_DONE_V + 20, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (done_at != EXP_DONE_V) begin errors++; $display("FAIL verify_done_at: got %0d expected %0d", done_at, EXP_DONE_V); end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL verify_done_count: got %0d expected 1", n_done); end
    checks++;
    if (rst_low != RC) begin errors++; $display("FAIL verify_rstn_low: got %0d expected %0d", rst_low, RC); end
    checks++;
    if (loads != 2) begin errors++; $display("FAIL verify_load_pulses: got %0d expected 2", loads); end
    checks++;
    if (cks != 2 * FL) begin errors++; $display("FAIL verify_ck_cycles: got %0d expected %0d", cks, 2 * FL); end
    checks++;
    if (crc_err[0] !== 1'b0) begin errors++; $display("FAIL verify_crc_err: got %b expected 0", crc_err[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL verify_busy_end: got %b expected 0", busy[0]); end
  endtask

  task automatic test_crc_error();
    int done_at, n_done, rst_low, loads, cks;
    logic exp_err;
    rand_frame(0);
    flip_en[0] = 1'b1;
    exp_err = (ref_crc(frame[0], -1) != ref_crc(frame[0], FLIP_POS));
    pulse_start(0);
    watch(0, EXP_DONE_V + 20, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (done_at != EXP_DONE_V || n_done != 1) begin
      errors++; $display("FAIL crcerr_done: got at %0d x%0d expected at %0d x1", done_at, n_done, EXP_DONE_V);
    end
    checks++;
    if (crc_err[0] !== exp_err) begin errors++; $display("FAIL crcerr_flag: got %b expected %b", crc_err[0], exp_err); end
    repeat (50) @(negedge clk);
    checks++;
    if (crc_err[0] !== exp_err) begin errors++; $display("FAIL crcerr_sticky: got %b expected %b", crc_err[0], exp_err); end
    flip_en[0] = 1'b0;
    rand_frame(0);
    pulse_start(0);
    checks++;
    if (crc_err[0] !== 1'b0) begin errors++; $display("FAIL crcerr_clear_on_start: got %b expected 0", crc_err[0]); end
    watch(0, EXP_DONE_V + 20, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (done_at != EXP_DONE_V || crc_err[0] !== 1'b0) begin
      errors++; $display("FAIL crcerr_rerun: got at %0d err %b expected at %0d err 0", done_at, crc_err[0], EXP_DONE_V);
    end
  endtask

  task automatic test_single_pass();
    int done_at, n_done, rst_low, loads, cks;
    rand_frame(1);
    flip_en[1] = 1'b0;
    pulse_start(1);
    watch(1, EXP_DONE_S + 20, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (done_at != EXP_DONE_S) begin errors++; $display("FAIL single_done_at: got %0d expected %0d", done_at, EXP_DONE_S); end
    checks++;
    if (loads != 1) begin errors++; $display("FAIL single_load_pulses: got %0d expected 1", loads); end
    checks++;
    if (cks != FL) begin errors++; $display("FAIL single_ck_cycles: got %0d expected %0d", cks, FL); end
    checks++;
    if (rst_low != RC || n_done != 1 || crc_err[1] !== 1'b0) begin
      errors++; $display("FAIL single_status: got rstlow %0d done %0d err %b expected %0d 1 0", rst_low, n_done, crc_err[1], RC);
    end
  endtask

  // Abort at cycle k after start; returns one cycle after the abort is taken.
  task automatic do_abort(input int k, input string tag);
    int done_at, n_done, rst_low, loads, cks;
    logic [6:0] got;
    rand_frame(0);
    pulse_start(0);
    repeat (k) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    got = {busy[0], aborted[0], ck_en[0], rstn_sc[0], load[0], shift_en[0], done[0]};
    checks++;
    if (got !== 7'b0100000) begin
      errors++; $display("FAIL %s_outputs (k=%0d): got %b expected %b", tag, k, got, 7'b0100000);
    end
    watch(0, 40, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (n_done != 0 || rst_low != 1 || aborted[0] !== 1'b1) begin
      errors++; $display("FAIL %s_after (k=%0d): got done %0d rstlow %0d ab %b expected 0 1 1", tag, k, n_done, rst_low, aborted[0]);
    end
  endtask

  task automatic test_abort();
    int done_at, n_done, rst_low, loads, cks;
    rand_frame(0);
    pulse_start(0);
    repeat (RC + 1 + 300) @(negedge clk);
    checks++;
    if (shift_en[0] !== 1'b1) begin errors++; $display("FAIL abort_in_shift1: got %b expected 1", shift_en[0]); end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    checks++;
    if ({busy[0], aborted[0], ck_en[0], rstn_sc[0], load[0], shift_en[0]} !== 6'b010000) begin
      errors++; $display("FAIL abort_outputs: got %b expected 010000",
                         {busy[0], aborted[0], ck_en[0], rstn_sc[0], load[0], shift_en[0]});
    end
    watch(0, 40, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (n_done != 0 || rst_low != 1) begin
      errors++; $display("FAIL abort_after: got done %0d rstlow %0d expected 0 1", n_done, rst_low);
    end
    for (int r = 0; r < 3; r++) do_abort(int'($urandom_range(0, EXP_DONE_V - 1)), "abort_rand");
    rand_frame(0);
    pulse_start(0);
    checks++;
    if (aborted[0] !== 1'b0) begin errors++; $display("FAIL abort_clear_on_start: got %b expected 0", aborted[0]); end
    watch(0, EXP_DONE_V + 20, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (done_at != EXP_DONE_V || crc_err[0] !== 1'b0) begin
      errors++; $display("FAIL abort_rerun: got at %0d err %b expected at %0d err 0", done_at, crc_err[0], EXP_DONE_V);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0, done_at = -1, loads = 0;
    rand_frame(0);
    pulse_start(0);
    for (int k = 1; k <= EXP_DONE_V + 130; k++) begin
      @(negedge clk);
      if (done[0]) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (load[0]) loads++;
      start[0] = (k == 10 || k == 500);
    end
    start[0] = 1'b0;
    checks++;
    if (n_done != 1 || done_at != EXP_DONE_V) begin
      errors++; $display("FAIL busy_start_done: got x%0d at %0d expected x1 at %0d", n_done, done_at, EXP_DONE_V);
    end
    checks++;
    if (loads != 2) begin errors++; $display("FAIL busy_start_loads: got %0d expected 2", loads); end
  endtask

  task automatic test_start_abort_same();
    int done_at, n_done, rst_low, loads, cks;
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || aborted[0] !== 1'b0 || rstn_sc[0] !== 1'b1) begin
      errors++; $display("FAIL start_abort_same: got busy %b ab %b rstn %b expected 0 0 1", busy[0], aborted[0], rstn_sc[0]);
    end
    watch(0, 20, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (n_done != 0 || loads != 0 || rst_low != 0) begin
      errors++; $display("FAIL start_abort_idle: got done %0d load %0d rstlow %0d expected 0 0 0", n_done, loads, rst_low);
    end
  endtask

  task automatic test_rst_mid();
    int done_at, n_done, rst_low, loads, cks;
    logic [7:0] got;
    rand_frame(0);
    pulse_start(0);
    repeat (RC + 2 * (FL + 1) - FL - 1 + 200 + 1) @(negedge clk);
    checks++;
    if (shift_en[0] !== 1'b1 || ck_en[0] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_in_shift2: got %b%b expected 11", shift_en[0], ck_en[0]);
    end
    #20 rst = 1'b1;
    #1;
    got = {load[0], shift_en[0], ck_en[0], rstn_sc[0], busy[0], done[0], crc_err[0], aborted[0]};
    checks++;
    if (got !== 8'b0001_0000) begin
      errors++; $display("FAIL rst_mid_async: got %b expected %b", got, 8'b0001_0000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rand_frame(0);
    pulse_start(0);
    watch(0, EXP_DONE_V + 20, done_at, n_done, rst_low, loads, cks);
    checks++;
    if (done_at != EXP_DONE_V || n_done != 1 || crc_err[0] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rerun: got at %0d x%0d err %b expected at %0d x1 err 0", done_at, n_done, crc_err[0], EXP_DONE_V);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst     = 1'b1;
    start   = '0;
    abort   = '0;
    flip_en = '0;
    frame[0] = '0;
    frame[1] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_verify_ok();
    test_crc_error();
    test_single_pass();
    test_abort();
    test_back_to_back();
    test_start_abort_same();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(200.0 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
